// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level transforms used by the
// encrypt/decrypt blocks of the SD-card data path.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINAL} dec_state_t;

  // Index 0 and 11..15 are padding so a 4-bit round index never leaves the table.
  localparam byte_t RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic byte_t sbox(input byte_t b);
    byte_t s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic byte_t inv_sbox(input byte_t b);
    byte_t s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
    endcase
    return s;
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add over the constant's bits; with constant c this folds to xtime/XOR chains.
  function automatic byte_t gf_mul(input byte_t a, input byte_t c);
    byte_t p;
    byte_t r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte i lives at [127-8i -: 8]; state is column-major (row = i%4, col = i/4).
  function automatic block_t inv_shift_rows(input block_t s);
    block_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return r;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t r;
    byte_t a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: round key i from round key i-1.
// Purely combinational; shared by the encrypt and decrypt blocks.
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [3:0]   round_idx,
  output logic [127:0] next_key
);

  word_t temp_w;
  word_t acc_w;

  assign temp_w = sub_word(rot_word(prev_key[31:0])) ^ {RCON[round_idx], 24'h000000};

  // Each new word is the previous new word XOR the matching old word; word 0 seeds from temp.
  always_comb begin
    acc_w    = temp_w;
    next_key = '0;
    for (int k = 0; k < 4; k++) begin
      acc_w = acc_w ^ prev_key[127-32*k -: 32];
      next_key[127-32*k -: 32] = acc_w;
    end
  end

endmodule

// File: rtl/decryption_block.sv
// Iterative AES-128 inverse cipher: forward key expansion into a round-key
// store, then one inverse round per clock. 21 cycles per block.
module decryption_block
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_decrypt,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] final_data_out,
  output logic         dec_busy,
  output logic         dec_done
);

  localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS);
  localparam logic [3:0] FIRST_INV = 4'(NUM_ROUNDS - 1);

  dec_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  block_t     blk_q, blk_d;
  block_t     final_q, final_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Round-key store; contents are don't-care after reset, so it carries no reset.
  block_t     rk_q [0:NUM_ROUNDS];
  logic       rk_we;
  logic [3:0] rk_widx;
  block_t     rk_wdata;
  logic [3:0] rk_rd_idx;
  block_t     rk_rd;
  block_t     key_step;

  assign rk_rd = rk_q[rk_rd_idx];

  aes_key_expand_step u_key_step (
    .prev_key (rk_rd),
    .round_idx(cnt_q),
    .next_key (key_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    final_d   = final_q;
    done_d    = 1'b0;
    rk_we     = 1'b0;
    rk_widx   = cnt_q;
    rk_wdata  = key_step;
    rk_rd_idx = 4'd0;
    case (state_q)
      IDLE: begin
        if (enable_decrypt) begin
          blk_d    = data_in;
          rk_we    = 1'b1;
          rk_widx  = 4'd0;
          rk_wdata = key_in;
          cnt_d    = 4'd1;
          state_d  = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_rd_idx = cnt_q - 4'd1;
        rk_we     = 1'b1;
        if (cnt_q == LAST_RND) begin
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      INIT: begin
        rk_rd_idx = LAST_RND;
        blk_d     = blk_q ^ rk_rd;
        cnt_d     = FIRST_INV;
        state_d   = ROUND;
      end
      ROUND: begin
        rk_rd_idx = cnt_q;
        blk_d     = inv_mix_columns(inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_rd);
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        rk_rd_idx = 4'd0;
        final_d   = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk_rd;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Busy mirrors "not returning to IDLE", so it rises at the start edge and drops with done.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      blk_q   <= '0;
      final_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      final_q <= final_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_widx] <= rk_wdata;
  end

  assign final_data_out = final_q;
  assign dec_busy       = busy_q;
  assign dec_done       = done_q;

endmodule

// File: tb/tb_decryption_block.sv
// Directed FIPS-197 vectors through decryption_block with a queue scoreboard
// checked by an independent monitor on every dec_done pulse.
module tb_decryption_block;

  logic         clk;
  logic         rst;
  logic         enable_decrypt;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] final_data_out;
  logic         dec_busy;
  logic         dec_done;

  typedef struct {
    logic [127:0] pt;
    int           edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   busy_run = 0;
  int   last_busy_run = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] T_KEY  = 128'h5e74e7ba66b0c7cc1b7697b3f9f51527;
  localparam logic [127:0] T_CT   = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
  localparam logic [127:0] T_PT   = 128'h7d8ae0f7cfa0a6cb09fb5d05a8ec586d;

  decryption_block #(.NUM_ROUNDS(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_decrypt(enable_decrypt),
    .data_in       (data_in),
    .key_in        (key_in),
    .final_data_out(final_data_out),
    .dec_busy      (dec_busy),
    .dec_done      (dec_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per dec_done.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (dec_busy === 1'b1) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
    if (dec_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_done: got dec_done=1 at edge %0d expected no pulse", edge_cnt);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] done at edge %0d plaintext %h", edge_cnt, final_data_out);
        check("plaintext", final_data_out, e.pt);
        check("done_edge", 128'(edge_cnt), 128'(e.edge_no));
        check("busy_len", 128'(last_busy_run), 128'd21);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; the start is sampled at the next edge.
  task automatic start(input logic [127:0] ct, input logic [127:0] key,
                       input logic [127:0] pt, input bit expect_done);
    exp_t e;
    data_in = ct;
    key_in = key;
    enable_decrypt = 1'b1;
    if (expect_done) begin
      e.pt = pt;
      e.edge_no = edge_cnt + 1 + 21;
      exp_q.push_back(e);
    end
    step(1);
    enable_decrypt = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 80) begin
      step(1);
      waited++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, exp_q.size());
      exp_q.delete();
    end
    step(3);
  endtask

  initial begin
    int e0;
    rst = 1'b1;
    enable_decrypt = 1'b0;
    data_in = '0;
    key_in = '0;
    step(3);
    check("reset_out", final_data_out, 128'd0);
    check("reset_busy", 128'(dec_busy), 128'd0);
    check("reset_done", 128'(dec_done), 128'd0);
    rst = 1'b0;
    step(2);

    // FIPS-197 C.1 single pulse
    start(C1_CT, C1_KEY, C1_PT, 1'b1);
    check("busy_after_start", 128'(dec_busy), 128'd1);
    drain("c1");

    // FIPS-197 Appendix B
    start(B_CT, B_KEY, B_PT, 1'b1);
    drain("fips_b");

    // Team encryption vector round trip
    start(T_CT, T_KEY, T_PT, 1'b1);
    drain("team");

    // Busy-ignore: new data and enable mid-operation must not disturb the result
    start(C1_CT, C1_KEY, C1_PT, 1'b1);
    step(4);
    data_in = '1;
    enable_decrypt = 1'b1;
    step(1);
    enable_decrypt = 1'b0;
    check("busy_during_ignore", 128'(dec_busy), 128'd1);
    drain("busy_ignore");
    step(20);

    // Reset mid-op, with enable also high at the reset edge
    start(B_CT, B_KEY, B_PT, 1'b0);
    step(11);
    rst = 1'b1;
    enable_decrypt = 1'b1;
    step(1);
    rst = 1'b0;
    enable_decrypt = 1'b0;
    check("abort_out_cleared", final_data_out, 128'd0);
    check("abort_busy", 128'(dec_busy), 128'd0);
    check("abort_done", 128'(dec_done), 128'd0);
    step(1);
    check("rst_wins_no_start", 128'(dec_busy), 128'd0);
    step(25);
    start(B_CT, B_KEY, B_PT, 1'b1);
    drain("after_reset");

    // Back-to-back with enable held: C.1 then B
    begin
      exp_t e;
      e0 = edge_cnt + 1;
      e.pt = C1_PT; e.edge_no = e0 + 21; exp_q.push_back(e);
      e.pt = B_PT;  e.edge_no = e0 + 43; exp_q.push_back(e);
    end
    data_in = C1_CT;
    key_in = C1_KEY;
    enable_decrypt = 1'b1;
    step(2);
    data_in = B_CT;
    key_in = B_KEY;
    step(21);
    enable_decrypt = 1'b0;
    step(8);
    check("hold_between_pulses", final_data_out, C1_PT);
    drain("back_to_back");
    step(25);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "global timeout");
  end

endmodule
